// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus frame pacer feeding a UART transmitter that has no busy output.
// Optional statistics counters (tx_count, drop_count) when UART_TX_FEEDER_STATS_EN is defined.
module uart_tx_feeder #(
  parameter int unsigned INPUT_CLK  = 50000000,
  parameter int unsigned BAUD_RATE  = 230400,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned GAP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [7:0]            send_byte,
  output logic                  send_en,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic                  overflow
`ifdef UART_TX_FEEDER_STATS_EN
  ,
  output logic [15:0]           tx_count,
  output logic [7:0]            drop_count
`endif
);

  localparam int unsigned DEPTH        = 2 ** DEPTH_LOG2;
  localparam int unsigned BIT_CYCLES   = INPUT_CLK / BAUD_RATE;
  localparam int unsigned FRAME_CYCLES = BIT_CYCLES * (10 + GAP_BITS);
  localparam int unsigned CNT_W        = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned LVL_W        = DEPTH_LOG2 + 1;
  localparam int unsigned PTR_W        = DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [7:0]         send_byte_q, send_byte_d;
  logic               send_en_q, send_en_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [DEPTH];

  logic               push;
  logic               pop;
  logic               rejected;

  // Ready is derived from the registered level, so a pop while full frees space next cycle
  assign wr_ready = (level_q != LVL_W'(DEPTH));
  assign push     = wr_valid & wr_ready;
  assign rejected = wr_valid & ~wr_ready;

  // Pacing FSM: pop decisions happen in IDLE or at the end of a frame gap
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        gap_d   = CNT_W'(FRAME_CYCLES - 1);
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == '0) begin
          if (level_q != '0) begin
            pop     = 1'b1;
            state_d = STROBE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    send_byte_d = send_byte_q;
    send_en_d   = (state_d == STROBE);
    busy_d      = (state_d != IDLE);
    overflow_d  = overflow_q | rejected;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      send_byte_d = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      send_byte_q <= 8'h00;
      send_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      send_byte_q <= send_byte_d;
      send_en_q   <= send_en_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign send_byte = send_byte_q;
  assign send_en   = send_en_q;
  assign level     = level_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

`ifdef UART_TX_FEEDER_STATS_EN
  logic [15:0] tx_count_q, tx_count_d;
  logic [7:0]  drop_count_q, drop_count_d;

  // tx_count wraps naturally; drop_count saturates
  always_comb begin
    tx_count_d   = tx_count_q;
    drop_count_d = drop_count_q;
    if (send_en_q) begin
      tx_count_d = tx_count_q + 16'(1);
    end
    if (rejected && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      tx_count_q   <= tx_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign tx_count   = tx_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule
